// File: rtl/gbt_tx_frame_gen.sv
// rtl/gbt_tx_frame_gen.sv - GBT e-link transmit frame generator with sync preamble and test patterns
module gbt_tx_frame_gen #(
  parameter int unsigned SYNC_FRAMES = 16,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         gbt_txrdy,
  input  logic [1:0]   mode,
  input  logic [111:0] user_data,
  input  logic         user_valid,
  input  logic         inject_err,
  output logic [111:0] data_o,
  output logic [1:0]   state_o,
  output logic [15:0]  frame_cnt,
  output logic [7:0]   underflow_cnt,
  output logic [7:0]   err_inj_cnt
);

  localparam int LANES = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  typedef logic [LANES-1:0][6:0] prbs_vec_t;

  // Lane k starts its PRBS7 sequence from k+1 so no lane is ever seeded to zero.
  function automatic prbs_vec_t prbs_seeds();
    prbs_vec_t v;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      v[k] = 7'(k + 1);
    end
    return v;
  endfunction

  localparam prbs_vec_t PRBS_SEEDS = prbs_seeds();

  // Advance x^7+x^6+1 by eight steps; returns {byte, next_state}, first generated bit in byte[7].
  function automatic logic [14:0] prbs7_step8(input logic [6:0] seed);
    logic [6:0] s;
    logic [7:0] b;
    logic       nb;
    s  = seed;
    b  = '0;
    nb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      nb = s[6] ^ s[5];
      s  = {s[5:0], nb};
      b  = {b[6:0], nb};
    end
    return {b, s};
  endfunction

  state_t                 state_q;
  logic [7:0]             sync_cnt_q;
  logic [1:0]             mode_q;
  logic [7:0]             cnt8_q;
  prbs_vec_t              prbs_q;
  logic                   pend_q;

  logic [111:0]           run_frame_d;
  prbs_vec_t              prbs_d;
  logic [LANES-1:0][14:0] prbs_st;
  logic                   sync_done;
  logic                   run_emit;

  assign state_o   = state_q;
  assign sync_done = (sync_cnt_q == 8'(SYNC_FRAMES));

  // A RUN frame goes out when sync completes or RUN continues with an unchanged mode.
  assign run_emit = gbt_txrdy &&
                    (((state_q == ST_SYNC) && sync_done) ||
                     ((state_q == ST_RUN) && (mode == mode_q)));

  // Payload for the next RUN frame from the current generator state, plus advanced PRBS state.
  always_comb begin
    run_frame_d = '0;
    prbs_d      = prbs_q;
    prbs_st     = '0;
    for (int k = 0; k < LANES; k++) begin
      prbs_st[k] = prbs7_step8(prbs_q[k]);
      prbs_d[k]  = prbs_st[k][6:0];
      case (mode_q)
        2'd0:    run_frame_d[8*k +: 8] = user_valid ? user_data[8*k +: 8] : IDLE_BYTE;
        2'd1:    run_frame_d[8*k +: 8] = cnt8_q + 8'(k);
        2'd2:    run_frame_d[8*k +: 8] = prbs_st[k][14:7];
        default: run_frame_d[8*k +: 8] = 8'h01 << (cnt8_q[2:0] + 3'(k));
      endcase
    end
  end

  // Frame FSM with registered frame, state, counters and error-injection flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      data_o        <= {LANES{IDLE_BYTE}};
      sync_cnt_q    <= '0;
      mode_q        <= '0;
      cnt8_q        <= '0;
      prbs_q        <= PRBS_SEEDS;
      pend_q        <= 1'b0;
      frame_cnt     <= '0;
      underflow_cnt <= '0;
      err_inj_cnt   <= '0;
    end else begin
      pend_q <= pend_q | inject_err;
      if (run_emit) begin
        state_q   <= ST_RUN;
        data_o    <= run_frame_d ^ {111'd0, pend_q};
        cnt8_q    <= cnt8_q + 8'd1;
        prbs_q    <= prbs_d;
        frame_cnt <= frame_cnt + 16'd1;
        if ((mode_q == 2'd0) && !user_valid && (underflow_cnt != 8'hFF)) begin
          underflow_cnt <= underflow_cnt + 8'd1;
        end
        if (pend_q) begin
          // A request arriving on the consuming edge survives for the next frame.
          pend_q <= inject_err;
          if (err_inj_cnt != 8'hFF) begin
            err_inj_cnt <= err_inj_cnt + 8'd1;
          end
        end
      end else begin
        // Outside RUN the generators sit at their seeds so RUN always starts fresh.
        cnt8_q <= '0;
        prbs_q <= PRBS_SEEDS;
        if (!gbt_txrdy) begin
          state_q <= ST_IDLE;
          data_o  <= {LANES{IDLE_BYTE}};
        end else if (state_q == ST_SYNC) begin
          sync_cnt_q <= sync_cnt_q + 8'd1;
          data_o     <= {LANES{SYNC_BYTE}};
        end else begin
          // IDLE with transmitter ready, or RUN with a mode change: (re)start the preamble.
          state_q    <= ST_SYNC;
          sync_cnt_q <= 8'd1;
          mode_q     <= mode;
          data_o     <= {LANES{SYNC_BYTE}};
        end
      end
    end
  end

endmodule

// File: tb/tb_gbt_tx_frame_gen.sv
// tb/tb_gbt_tx_frame_gen.sv - directed table and sequence checks for gbt_tx_frame_gen
module tb_gbt_tx_frame_gen;

  logic         clock = 1'b0;
  logic         reset;
  logic         gbt_txrdy;
  logic [1:0]   mode;
  logic [111:0] user_data;
  logic         user_valid;
  logic         inject_err;
  logic [111:0] data_o;
  logic [1:0]   state_o;
  logic [15:0]  frame_cnt;
  logic [7:0]   underflow_cnt;
  logic [7:0]   err_inj_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clock = ~clock;

  gbt_tx_frame_gen dut (
    .clock        (clock),
    .reset        (reset),
    .gbt_txrdy    (gbt_txrdy),
    .mode         (mode),
    .user_data    (user_data),
    .user_valid   (user_valid),
    .inject_err   (inject_err),
    .data_o       (data_o),
    .state_o      (state_o),
    .frame_cnt    (frame_cnt),
    .underflow_cnt(underflow_cnt),
    .err_inj_cnt  (err_inj_cnt)
  );

  localparam logic [111:0] IDLE_F = {14{8'h00}};
  localparam logic [111:0] SYNC_F = {14{8'hA5}};

  typedef struct {
    logic         valid;
    logic         inject;
    logic [111:0] udata;
    logic [111:0] exp_data;
    logic [7:0]   exp_uf;
    logic [7:0]   exp_err;
  } vec_t;

  vec_t vecs[8];
  int   prbs_m[14];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [111:0] act, input logic [111:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [111:0] cnt_frame(input int c);
    logic [111:0] f;
    f = '0;
    for (int k = 0; k < 14; k++) f[8*k +: 8] = 8'((c + k) % 256);
    return f;
  endfunction

  function automatic logic [111:0] walk_frame(input int c);
    logic [111:0] f;
    f = '0;
    for (int k = 0; k < 14; k++) f[8*k +: 8] = 8'(1 << ((c + k) % 8));
    return f;
  endfunction

  task automatic prbs_model_frame(output logic [111:0] f);
    int s, nb, b;
    f = '0;
    for (int k = 0; k < 14; k++) begin
      s = prbs_m[k];
      b = 0;
      for (int i = 0; i < 8; i++) begin
        nb = ((s >> 6) ^ (s >> 5)) & 1;
        s  = ((s << 1) | nb) & 127;
        b  = ((b << 1) | nb) & 255;
      end
      f[8*k +: 8] = 8'(b);
      prbs_m[k] = s;
    end
  endtask

  task automatic sync_phase(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (state_o === 2'd1 && data_o === SYNC_F) ok++;
    end
    check({name, "_sync16"}, 112'(ok), 112'd16);
  endtask

  initial begin
    logic [111:0] exp_f;
    int bad;

    vecs[0] = '{1'b1, 1'b0, {14{8'h5A}}, {14{8'h5A}},            8'd0, 8'd1};
    vecs[1] = '{1'b0, 1'b0, {14{8'hFF}}, IDLE_F,                 8'd1, 8'd1};
    vecs[2] = '{1'b1, 1'b0, {14{8'h3C}}, {14{8'h3C}},            8'd1, 8'd1};
    vecs[3] = '{1'b1, 1'b1, {14{8'hC3}}, {14{8'hC3}},            8'd1, 8'd1};
    vecs[4] = '{1'b1, 1'b0, {14{8'h96}}, {14{8'h96}} ^ 112'd1,   8'd1, 8'd2};
    vecs[5] = '{1'b1, 1'b1, {14{8'h69}}, {14{8'h69}},            8'd1, 8'd2};
    vecs[6] = '{1'b0, 1'b1, {14{8'h77}}, IDLE_F ^ 112'd1,        8'd2, 8'd3};
    vecs[7] = '{1'b1, 1'b0, {14{8'hE7}}, {14{8'hE7}} ^ 112'd1,   8'd2, 8'd4};

    reset      = 1'b1;
    gbt_txrdy  = 1'b0;
    mode       = 2'd1;
    user_data  = '0;
    user_valid = 1'b0;
    inject_err = 1'b0;
    step();
    step();
    check("rst_state", 112'(state_o), 112'd0);
    check("rst_data", data_o, IDLE_F);
    check("rst_frame_cnt", 112'(frame_cnt), 112'd0);
    check("rst_uf_cnt", 112'(underflow_cnt), 112'd0);
    check("rst_err_cnt", 112'(err_inj_cnt), 112'd0);

    reset = 1'b0;
    step();
    check("idle_hold_state", 112'(state_o), 112'd0);

    // Preamble in mode 1 with two error requests one cycle apart.
    gbt_txrdy = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      inject_err = (i == 3 || i == 5);
      step();
      if (state_o === 2'd1 && data_o === SYNC_F) bad++;
    end
    inject_err = 1'b0;
    check("first_sync16", 112'(bad), 112'd16);

    bad = 0;
    for (int f = 0; f < 300; f++) begin
      step();
      exp_f = cnt_frame(f);
      if (f == 0) exp_f[0] = ~exp_f[0];
      if (state_o !== 2'd2 || data_o !== exp_f) bad++;
      if (f == 0) begin
        check("run1_state", 112'(state_o), 112'd2);
        check("run1_lane0_inj", 112'(data_o[7:0]), 112'h01);
        check("run1_lane13", 112'(data_o[111:104]), 112'h0D);
        check("run1_err_cnt", 112'(err_inj_cnt), 112'd1);
      end
      if (f == 1) begin
        check("run2_lane0", 112'(data_o[7:0]), 112'h01);
        check("run2_err_cnt", 112'(err_inj_cnt), 112'd1);
      end
      if (f == 256) check("cnt8_wrap_lane0", 112'(data_o[7:0]), 112'h00);
    end
    check("mode1_300_frames", 112'(bad), 112'd0);
    check("frame_cnt_300", 112'(frame_cnt), 112'd300);

    // Mode change to walking-one restarts the preamble and the pattern.
    mode = 2'd3;
    sync_phase("walk");
    for (int f = 0; f < 3; f++) begin
      step();
      check($sformatf("walk%0d_frame", f), data_o, walk_frame(f));
      if (f == 0) begin
        check("walk0_lane13", 112'(data_o[111:104]), 112'h20);
        check("walk0_frame_cnt", 112'(frame_cnt), 112'd301);
      end
    end

    // PRBS7 against the bench model for 10000 frames.
    mode = 2'd2;
    sync_phase("prbs");
    for (int k = 0; k < 14; k++) prbs_m[k] = k + 1;
    bad = 0;
    for (int f = 0; f < 10000; f++) begin
      step();
      prbs_model_frame(exp_f);
      if (state_o !== 2'd2 || data_o !== exp_f) bad++;
      if (f == 0) begin
        check("prbs0_lane0", 112'(data_o[7:0]), 112'h06);
        check("prbs0_lane13", 112'(data_o[111:104]), 112'h24);
      end
    end
    check("prbs_10000", 112'(bad), 112'd0);

    // Transmitter-ready drop mid-RUN.
    gbt_txrdy = 1'b0;
    step();
    check("drop_state", 112'(state_o), 112'd0);
    check("drop_data", data_o, IDLE_F);
    check("drop_frame_cnt_kept", 112'(frame_cnt), 112'd10303);

    // Mode 0 user data table.
    gbt_txrdy = 1'b1;
    mode      = 2'd0;
    sync_phase("user");
    for (int i = 0; i < 8; i++) begin
      user_valid = vecs[i].valid;
      user_data  = vecs[i].udata;
      inject_err = vecs[i].inject;
      step();
      check($sformatf("vec%0d_data", i), data_o, vecs[i].exp_data);
      check($sformatf("vec%0d_uf", i), 112'(underflow_cnt), 112'(vecs[i].exp_uf));
      check($sformatf("vec%0d_err", i), 112'(err_inj_cnt), 112'(vecs[i].exp_err));
    end
    inject_err = 1'b0;
    user_valid = 1'b0;
    for (int i = 0; i < 300; i++) step();
    check("uf_saturate", 112'(underflow_cnt), 112'd255);
    check("uf_idle_data", data_o, IDLE_F);

    // Reset while in RUN.
    reset = 1'b1;
    step();
    check("rst2_state", 112'(state_o), 112'd0);
    check("rst2_data", data_o, IDLE_F);
    check("rst2_frame_cnt", 112'(frame_cnt), 112'd0);
    check("rst2_uf_cnt", 112'(underflow_cnt), 112'd0);
    check("rst2_err_cnt", 112'(err_inj_cnt), 112'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gbt_tx_frame_gen.md
# gbt_tx_frame_gen

Builds the 112-bit frame presented each 40 MHz cycle to the 14-lane GBT e-link serializer (`optical_gbt`, `data_i`). It gates transmission on the GBT transmitter-ready status and emits an idle/sync preamble before payload. It then sources one of four payloads per lane: user data, per-lane counter, per-lane PRBS7, or walking-one. The block runs on the global 40 MHz frame clock that drives the serializer's OSERDES `CLKDIV`.

## Interface
Parameters:
- `SYNC_FRAMES`, 16: number of sync frames sent before RUN (1-255).
- `IDLE_BYTE`, 8'h00: per-lane byte sent in IDLE and on user underflow.
- `SYNC_BYTE`, 8'hA5: per-lane byte sent in SYNC.

Ports:
- `clock`, in, 1: 40 MHz frame clock (BUFG domain).
- `reset`, in, 1: synchronous, active-high.
- `gbt_txrdy`, in, 1: GBT transmitter ready; synchronous to `clock`.
- `mode`, in, 2: 0 user, 1 counter, 2 PRBS7, 3 walking-one.
- `user_data`, in, 112: user payload; lane k is `[8k+7:8k]`.
- `user_valid`, in, 1: `user_data` valid this cycle.
- `inject_err`, in, 1: single-cycle request to corrupt one frame.
- `data_o`, out, 112: frame to the serializer.
- `state_o`, out, 2: 0 IDLE, 1 SYNC, 2 RUN.
- `frame_cnt`, out, 16: RUN frames sent; wraps.
- `underflow_cnt`, out, 8: user-mode frames with `user_valid`=0; saturates at 255.
- `err_inj_cnt`, out, 8: errors injected; saturates at 255.

## Operation
- FSM:
  - IDLE → SYNC when `gbt_txrdy`=1.
  - SYNC lasts exactly `SYNC_FRAMES` cycles → RUN.
  - From SYNC or RUN, `gbt_txrdy`=0 → IDLE in the next cycle; this has priority over all other transitions.
  - In RUN, a change of `mode` from the value latched on SYNC entry → SYNC. The sync counter restarts, and pattern generators reseed on SYNC exit.
- IDLE: every lane = `IDLE_BYTE`. SYNC: every lane = `SYNC_BYTE`.
- RUN payloads, lane k (0..13):
  - Mode 0: lane = `user_data` lane if `user_valid`, else `IDLE_BYTE`. An invalid frame increments `underflow_cnt`.
  - Mode 1: lane = `cnt8 + k` (mod 256). `cnt8` is 0 on the first RUN frame and increments by 1 per frame.
  - Mode 2: independent PRBS7 per lane, x^7+x^6+1, seeded to 7'(k+1) at RUN entry. Each frame advances 8 steps. The byte holds the 8 generated bits, first bit in bit 7.
  - Mode 3: lane k = `8'h01 << ((cnt8 + k) mod 8)`.
- Error injection:
  - `inject_err` sets a pending flag in any state, and in any mode including mode 0. Multiple pulses before use collapse into one.
  - The first RUN frame after the flag is set is emitted with bit 0 of lane 0 inverted. The flag is then cleared and `err_inj_cnt` increments.
  - The pattern generators are unaffected by the inversion.
  - When `inject_err` coincides with a frame consuming an earlier pending flag, the new request stays pending.
- `frame_cnt` increments on every RUN frame and wraps 0xFFFF → 0. It is not cleared by leaving RUN.
- Reset:
  - Outputs: `state_o`=IDLE, `data_o`={14{`IDLE_BYTE`}}, all counters 0, pending flag 0.
  - Generator state: `cnt8`=0, PRBS lanes reseeded.
  - Reset mid-frame takes effect on the next edge regardless of state.

## Timing
- `data_o` and `state_o` are registered and change together. The output frame reflects the state entered on the same edge.
- `user_data` sampled at edge n appears on `data_o` after edge n; latency is 1 cycle.
- `gbt_txrdy` rising at edge n yields SYNC frames on cycles n+1 … n+`SYNC_FRAMES`. The first RUN frame follows at n+`SYNC_FRAMES`+1.
- `gbt_txrdy` low sampled at edge n yields `IDLE_BYTE` frames from n+1.
- Counters update on the same edge as the frame they describe.

## Test plan
- Reset, then `gbt_txrdy`=1 with default params: `data_o`=all 8'hA5 for exactly 16 cycles, then RUN. `state_o` sequence is 0,1,2.
- Mode 1, 300 RUN frames: first frame lane k = k (lane 13 = 8'h0D). Frame 256 returns to lane 0 = 8'h00. `frame_cnt`=300.
- Mode 2: first RUN frame lane 0 matches a PRBS7 model seeded 7'h01, lane 13 matches seed 7'h0E. A reference checker matches 10 000 frames with zero mismatches.
- Mode 0 with `user_valid` toggling 1,0,1: output is payload, then all 8'h00, then payload, each 1 cycle late. `underflow_cnt`=1. After 300 invalid frames, `underflow_cnt`=255.
- Two `inject_err` pulses 1 cycle apart, both issued during SYNC in mode 1: only the first RUN frame has lane 0 = 8'h01. `err_inj_cnt`=1, and the next frame's lane 0 = 8'h01 (the count continues).
- `gbt_txrdy` dropped mid-RUN and a `mode` change mid-RUN: the first gives IDLE on the next frame; the second gives 16 SYNC frames, then the new pattern from its initial value.
